// File: rtl/router_pkg.sv
// Shared router definitions: direction encodings, port indices, default widths.
package router_pkg;

    localparam int unsigned NUM_PORTS  = 5;
    localparam int unsigned DATA_WIDTH = 64;

    // One-hot direction codes, bit order L,R,U,D,PE from MSB to LSB
    localparam logic [4:0] DIR_L  = 5'b10000;
    localparam logic [4:0] DIR_R  = 5'b01000;
    localparam logic [4:0] DIR_U  = 5'b00100;
    localparam logic [4:0] DIR_D  = 5'b00010;
    localparam logic [4:0] DIR_PE = 5'b00001;

    // Bit positions of each source inside req_in / data_in / clear_o
    localparam int unsigned PORT_L  = 4;
    localparam int unsigned PORT_R  = 3;
    localparam int unsigned PORT_U  = 2;
    localparam int unsigned PORT_D  = 1;
    localparam int unsigned PORT_PE = 0;

    // Output buffer occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } oi_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches downward from the pointer with wrap,
// pointer moves to the bit below the winner when the grant is taken.
module rr_arbiter #(
    parameter int unsigned NUM_PORTS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 adv,
    output logic [NUM_PORTS-1:0] grant
);

    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] next_ptr;
    logic [PW-1:0] idx_b;
    logic          found;
    int unsigned   ptr_u;
    int unsigned   idx;

    // First requesting bit in order ptr, ptr-1, ..., 0, N-1, ..., ptr+1
    always_comb begin
        grant    = '0;
        next_ptr = ptr_q;
        found    = 1'b0;
        idx      = 0;
        idx_b    = '0;
        ptr_u    = '0;
        ptr_u[PW-1:0] = ptr_q;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = ptr_u + NUM_PORTS - i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            idx_b = PW'(idx);
            if (!found && req[idx_b]) begin
                grant[idx_b] = 1'b1;
                found        = 1'b1;
                next_ptr     = (idx == 0) ? PW'(NUM_PORTS - 1) : PW'(idx - 1);
            end
        end
    end

    // Pointer register, reset to bit0 (PE)
    always_ff @(posedge clk) begin
        if (rst)      ptr_q <= '0;
        else if (adv) ptr_q <= next_ptr;
    end

endmodule

// File: rtl/output_interface.sv
// Output side of one router port: round-robin selection among the input
// interfaces, one-deep output buffer, buffer-clear return, so/ro link.
module output_interface
    import router_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = router_pkg::DATA_WIDTH,
    parameter int unsigned          NUM_PORTS  = router_pkg::NUM_PORTS,
    parameter logic [NUM_PORTS-1:0] DIRECTION  = router_pkg::DIR_L
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           req_in,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
    output logic [NUM_PORTS-1:0]           clear_o,
    output logic                           so,
    input  logic                           ro,
    output logic [DATA_WIDTH-1:0]          datao
);

    oi_state_t             state_q;
    logic [NUM_PORTS-1:0]  eligible;
    logic [NUM_PORTS-1:0]  grant;
    logic                  load;
    logic [DATA_WIDTH-1:0] sel_data;

    // No U-turn, and no regrant to a source whose req is still falling after its clear
    assign eligible = req_in & ~DIRECTION & ~clear_o;

    // Load when empty or when the held flit leaves on this edge
    assign load = ((state_q == ST_EMPTY) || ro) && (|grant);

    rr_arbiter #(
        .NUM_PORTS(NUM_PORTS)
    ) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (eligible),
        .adv  (load),
        .grant(grant)
    );

    // Flit of the granted source
    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            if (grant[k]) sel_data = data_in[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Buffer FSM, flit register and one-cycle clear pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            datao   <= '0;
            clear_o <= '0;
        end else begin
            clear_o <= load ? grant : '0;
            case (state_q)
                ST_EMPTY: begin
                    if (load) begin
                        state_q <= ST_FULL;
                        datao   <= sel_data;
                    end
                end
                ST_FULL: begin
                    if (load) begin
                        datao <= sel_data;
                    end else if (ro) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign so = (state_q == ST_FULL);

endmodule

// File: tb/tb_output_interface.sv
// Directed bench for output_interface (DIRECTION = L) with a flit scoreboard.
module tb_output_interface;
    import router_pkg::*;

    localparam int unsigned DW = 64;
    localparam int unsigned NP = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     req_in;
    logic [NP*DW-1:0]  data_in;
    logic [NP-1:0]     clear_o;
    logic              so;
    logic              ro;
    logic [DW-1:0]     datao;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [DW-1:0] sb[$];
    logic [NP-1:0] rr_exp[4];

    output_interface #(
        .DATA_WIDTH(DW),
        .NUM_PORTS (NP),
        .DIRECTION (DIR_L)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_in (req_in),
        .data_in(data_in),
        .clear_o(clear_o),
        .so     (so),
        .ro     (ro),
        .datao  (datao)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int unsigned k, input logic [DW-1:0] v);
        data_in[k*DW +: DW] = v;
    endtask

    // Scoreboard: every link transfer must carry the next expected flit
    always @(negedge clk) begin
        if (!rst && so === 1'b1 && ro === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_transfer", datao, '0);
                checks++;
                errors++;
                $error("FAIL unexpected_transfer observed=%0h expected=none", datao);
            end else begin
                chk("transfer_data", datao, sb.pop_front());
            end
        end
    end

    initial begin
        rr_exp[0] = DIR_R; rr_exp[1] = DIR_U; rr_exp[2] = DIR_D; rr_exp[3] = DIR_PE;
        rst = 1'b1; ro = 1'b1; req_in = '0; data_in = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_so", {63'b0, so}, 64'd0);
        chk("reset_datao", datao, 64'd0);
        chk("reset_clear", {59'b0, clear_o}, 64'd0);

        // Single PE request
        set_data(PORT_PE, 64'hA5); req_in = DIR_PE; sb.push_back(64'hA5);
        tick();
        chk("single_so", {63'b0, so}, 64'd1);
        chk("single_datao", datao, 64'hA5);
        chk("single_clear", {59'b0, clear_o}, {59'b0, DIR_PE});
        req_in = '0;
        tick();
        chk("single_drained_so", {63'b0, so}, 64'd0);
        chk("single_clear_off", {59'b0, clear_o}, 64'd0);

        // U-turn request is ignored
        set_data(PORT_L, 64'hDEAD); req_in = DIR_L;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("uturn_so", {63'b0, so}, 64'd0);
            chk("uturn_clear", {59'b0, clear_o}, 64'd0);
        end
        req_in = '0;

        // Round-robin over R,U,D,PE at full rate
        set_data(PORT_R, 64'h30); set_data(PORT_U, 64'h20);
        set_data(PORT_D, 64'h10); set_data(PORT_PE, 64'h01);
        req_in = 5'b01111;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(64'h30); sb.push_back(64'h20);
            sb.push_back(64'h10); sb.push_back(64'h01);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_clear", {59'b0, clear_o}, {59'b0, rr_exp[i % 4]});
            chk("rr_so", {63'b0, so}, 64'd1);
        end
        req_in = '0;
        tick();
        chk("rr_drained_so", {63'b0, so}, 64'd0);

        // Backpressure holds the flit and blocks pending loads
        set_data(PORT_R, 64'h11); set_data(PORT_U, 64'h22);
        ro = 1'b0; req_in = DIR_R; sb.push_back(64'h11);
        tick();
        chk("bp_load_datao", datao, 64'h11);
        chk("bp_load_clear", {59'b0, clear_o}, {59'b0, DIR_R});
        req_in = DIR_U; sb.push_back(64'h22);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_hold_datao", datao, 64'h11);
            chk("bp_hold_clear", {59'b0, clear_o}, 64'd0);
            chk("bp_hold_so", {63'b0, so}, 64'd1);
        end
        ro = 1'b1;
        tick();
        chk("bp_release_datao", datao, 64'h22);
        chk("bp_release_clear", {59'b0, clear_o}, {59'b0, DIR_U});
        chk("bp_release_so", {63'b0, so}, 64'd1);
        req_in = '0;
        tick();
        chk("bp_drained_so", {63'b0, so}, 64'd0);

        // Request held one cycle past its clear is not granted twice
        set_data(PORT_D, 64'h33); req_in = DIR_D; sb.push_back(64'h33);
        tick();
        chk("dbl_clear", {59'b0, clear_o}, {59'b0, DIR_D});
        tick();
        chk("dbl_clear_off", {59'b0, clear_o}, 64'd0);
        chk("dbl_so", {63'b0, so}, 64'd0);
        req_in = '0;
        tick();
        chk("dbl_idle_so", {63'b0, so}, 64'd0);

        // Reset while holding a flit under backpressure
        set_data(PORT_PE, 64'h44); ro = 1'b0; req_in = DIR_PE;
        tick();
        chk("rst_pre_so", {63'b0, so}, 64'd1);
        req_in = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_so", {63'b0, so}, 64'd0);
        chk("rst_datao", datao, 64'd0);
        chk("rst_clear", {59'b0, clear_o}, 64'd0);
        set_data(PORT_L, 64'h51); set_data(PORT_R, 64'h52); set_data(PORT_U, 64'h53);
        set_data(PORT_D, 64'h54); set_data(PORT_PE, 64'h55);
        ro = 1'b1; req_in = 5'b11111; sb.push_back(64'h55);
        tick();
        chk("rst_ptr_clear", {59'b0, clear_o}, {59'b0, DIR_PE});
        chk("rst_ptr_datao", datao, 64'h55);
        req_in = '0;
        tick();
        chk("rst_final_so", {63'b0, so}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_interface.md
Name: output_interface

Overview:
Output side of one mesh-router port; the counterpart of the per-direction input interface. Collects routed requests from the five input interfaces (L, R, U, D, PE) destined for this output direction. Arbitrates round-robin, latches the winning flit into a one-deep output buffer and returns a one-cycle buffer-clear to the winner. Drives the outgoing link with the router's send/ready handshake (so/ro).

Parameters:
DATA_WIDTH, 64, flit width in bits
NUM_PORTS, 5, number of source input interfaces; fixed at 5 in this router
DIRECTION, 5'b10000, one-hot direction this output serves (L:10000, R:01000, U:00100, D:00010, PE:00001)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
req_in  input  5  request from each input interface to this output; bit4 L, bit3 R, bit2 U, bit1 D, bit0 PE
data_in  input  5*DATA_WIDTH  flits, slice k = data_in[k*DATA_WIDTH +: DATA_WIDTH], same bit order as req_in
clear_o  output  5  one-hot buffer-clear back to the granted input interface (drives its sig_buffer_clear)
so  output  1  send-out: output buffer holds a valid flit
ro  input  1  receive-ready from downstream router or PE
datao  output  DATA_WIDTH  flit presented on the link

Behaviour:
- Reset (synchronous, sampled at clk edge while rst=1): so=0, datao=0, clear_o=0, RR pointer=bit0 (PE). Reset mid-transfer discards the buffered flit; no clear_o is issued for it.
- Output buffer: one register plus valid bit; so = valid; datao = register (0 when never loaded or after reset).
- Transfer on link: occurs in any cycle with so=1 and ro=1. At that edge, valid clears unless reloaded in the same edge.
- Load condition per cycle: buffer empty, or draining this cycle (so & ro). Full throughput: one flit per cycle with ro held high.
- Eligible mask: req_in, minus the bit equal to DIRECTION (no U-turn; ignored even when 1), minus any bit whose clear_o is high this cycle. The last term prevents a double grant while the input interface's req is still falling.
- Arbitration: round-robin over eligible bits, searching from pointer downward with wrap (e.g. pointer=bit2: order 2,1,0,4,3). Winner g is the first eligible bit.
- On load: register <= data_in slice g, valid <= 1, clear_o <= one-hot(g) registered, so clear_o is high for exactly the next cycle. Pointer <= bit below g (wraps 0 -> 4).
- No eligible request or no load condition: no grant, clear_o <= 0, pointer unchanged.
- Latency: req_in sampled at edge t -> so=1 and clear_o[g]=1 during cycle t+1 -> earliest link transfer at edge t+1.
- Backpressure: ro=0 with so=1 holds datao stable and blocks loads. Pending requests wait, with no clear_o, until ro=1.
- Simultaneous drain and new request: new flit loads in the same edge; so stays 1; datao changes to the new flit.
- State machine (2 states, explicit): EMPTY (valid=0), FULL (valid=1).
  - EMPTY->FULL on grant.
  - FULL->EMPTY on transfer without grant.
  - FULL->FULL on transfer with grant, or when ro=0.
- clear_o always zero or one-hot; never asserted for the DIRECTION bit.

Decomposition:
- Shared package router_pkg: direction one-hot constants (DIR_L, DIR_R, DIR_U, DIR_D, DIR_PE), DATA_WIDTH default, port index constants.
- Sub-module rr_arbiter: NUM_PORTS-wide request/mask in, one-hot grant out, pointer register with advance enable. The remaining logic (buffer, FSM, clear_o register) stays in output_interface.

Test Plan:
- Single request, DIRECTION=10000: req_in=00001, data_in[PE]=64'hA5 (ro=1) -> cycle+1: so=1, datao=64'hA5, clear_o=00001; req dropped -> next cycle so=0.
- U-turn mask: DIRECTION=10000, req_in=10000 held 10 cycles -> so stays 0, clear_o stays 00000.
- Round-robin fairness: req_in=01111 held with ro=1 -> grant order R,U,D,PE,R..., one flit per cycle; clear_o follows 01000,00100,00010,00001.
- Backpressure: buffer holds 64'h11, ro=0 for 4 cycles with req_in=00100 pending -> datao=64'h11 stable, clear_o=0. ro=1 -> 64'h11 transfers; U flit loads at the same edge with clear_o=00100.
- No double grant: req_in[D] held high one extra cycle after clear_o[D] -> D granted once only.
- Reset mid-operation: so=1, ro=0, rst=1 for one cycle -> so=0, datao=0, clear_o=0, pointer=PE. Next grant with req_in=11111 selects PE.
